// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the UART debug controller.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_PRST = 8'h52;

    localparam int DUMP_WORDS     = 33;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_LEN,
        S_LOAD_BYTE,
        S_LOAD_END,
        S_PRST,
        S_RUN,
        S_STEP,
        S_DUMP_FETCH,
        S_DUMP_LATCH,
        S_DUMP_SEND
    } state_t;

endpackage

// File: rtl/debug_unit_word_tx.sv
// Serialises one word into bytes, MSB first, over a start/done byte handshake.
module dbg_word_tx
    import debug_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NB_DATA-1:0] word,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               done
);

    logic               busy;
    logic [1:0]         cnt;
    logic [NB_DATA-1:0] sr;
    logic               start_q;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            sr      <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (!busy && start) begin
                sr      <= word;
                cnt     <= '0;
                busy    <= 1'b1;
                start_q <= 1'b1;
            end else if (busy && tx_done) begin
                if (cnt == 2'(BYTES_PER_WORD - 1)) begin
                    busy   <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    sr      <= sr << NB_BYTE;
                    cnt     <= cnt + 2'd1;
                    start_q <= 1'b1;
                end
            end
        end
    end

    // The top byte of the shift register stays put until the next done.
    assign tx_data  = sr[NB_DATA-1 -: NB_BYTE];
    assign tx_start = start_q;
    assign done     = done_q;

endmodule

// File: rtl/debug_unit.sv
// Command FSM: instruction memory loader, run/step control and state dump.
module debug_unit
    import debug_pkg::*;
#(
    parameter int NB_DATA      = 32,
    parameter int NB_BYTE      = 8,
    parameter int NB_IMEM_ADDR = 10,
    parameter int NB_REG_ADDR  = 5
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NB_BYTE-1:0]      i_rx_data,
    input  logic                    i_rx_valid,
    output logic [NB_BYTE-1:0]      o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_done,
    output logic                    o_imem_w_en,
    output logic [NB_IMEM_ADDR-1:0] o_imem_w_addr,
    output logic [NB_DATA-1:0]      o_imem_w_data,
    output logic                    o_pipe_enable,
    output logic                    o_pipe_reset,
    input  logic                    i_halt,
    input  logic [NB_DATA-1:0]      i_pc,
    output logic [NB_REG_ADDR-1:0]  o_reg_r_addr,
    input  logic [NB_DATA-1:0]      i_reg_r_data
);

    state_t                  state;
    state_t                  state_next;
    logic [NB_BYTE-1:0]      words_left;
    logic [1:0]              byte_cnt;
    logic [NB_DATA-1:0]      word_sr;
    logic [NB_IMEM_ADDR-1:0] w_addr;
    logic                    w_en;
    logic [5:0]              word_idx;
    logic                    tx_go;
    logic                    tx_word_done;
    logic [NB_DATA-1:0]      tx_word;
    logic                    word_end;

    assign word_end = byte_cnt == 2'(BYTES_PER_WORD - 1);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_go      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD)      state_next = S_LOAD_LEN;
                    else if (i_rx_data == CMD_RUN)  state_next = S_RUN;
                    else if (i_rx_data == CMD_STEP) state_next = S_STEP;
                    else if (i_rx_data == CMD_PRST) state_next = S_PRST;
                end
            end
            S_LOAD_LEN: begin
                if (i_rx_valid) begin
                    if (i_rx_data == '0) state_next = S_IDLE;
                    else                 state_next = S_LOAD_BYTE;
                end
            end
            S_LOAD_BYTE: begin
                if (i_rx_valid && word_end && words_left == NB_BYTE'(1))
                    state_next = S_LOAD_END;
            end
            S_LOAD_END:   state_next = S_PRST;
            S_PRST:       state_next = S_IDLE;
            S_RUN: begin
                if (i_halt) state_next = S_DUMP_FETCH;
            end
            S_STEP:       state_next = S_DUMP_FETCH;
            S_DUMP_FETCH: state_next = S_DUMP_LATCH;
            S_DUMP_LATCH: begin
                tx_go      = 1'b1;
                state_next = S_DUMP_SEND;
            end
            S_DUMP_SEND: begin
                if (tx_word_done) begin
                    if (word_idx == 6'(DUMP_WORDS - 1)) state_next = S_IDLE;
                    else                                state_next = S_DUMP_FETCH;
                end
            end
            default:      state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            words_left <= '0;
            byte_cnt   <= '0;
            word_sr    <= '0;
            w_addr     <= '0;
            w_en       <= 1'b0;
            word_idx   <= '0;
        end else begin
            w_en <= 1'b0;
            if (w_en) w_addr <= w_addr + 1'b1;
            case (state)
                S_IDLE: begin
                    w_addr   <= '0;
                    byte_cnt <= '0;
                    word_idx <= '0;
                end
                S_LOAD_LEN: begin
                    if (i_rx_valid) words_left <= i_rx_data;
                end
                S_LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        word_sr  <= {word_sr[NB_DATA-NB_BYTE-1:0], i_rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_end) begin
                            w_en       <= 1'b1;
                            words_left <= words_left - 1'b1;
                        end
                    end
                end
                S_DUMP_SEND: begin
                    if (tx_word_done) word_idx <= word_idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Word 0 of the dump is the PC; word k reads register k-1.
    assign tx_word = (word_idx == '0) ? i_pc : i_reg_r_data;

    always_comb begin
        o_reg_r_addr = '0;
        if (word_idx != '0) o_reg_r_addr = NB_REG_ADDR'(word_idx - 6'd1);
    end

    assign o_imem_w_en   = w_en;
    assign o_imem_w_addr = w_addr;
    assign o_imem_w_data = word_sr;
    assign o_pipe_enable = (state == S_RUN || state == S_STEP) && !i_halt;
    assign o_pipe_reset  = state == S_PRST;

    dbg_word_tx #(
        .NB_DATA(NB_DATA),
        .NB_BYTE(NB_BYTE)
    ) u_word_tx (
        .clk     (i_clk),
        .reset   (i_reset),
        .start   (tx_go),
        .word    (tx_word),
        .tx_data (o_tx_data),
        .tx_start(o_tx_start),
        .tx_done (i_tx_done),
        .done    (tx_word_done)
    );

endmodule

// File: tb/tb_debug_unit.sv
// Directed/random bench for debug_unit with a byte-level reference model.
module tb_debug_unit;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done = 1'b0;
    logic        o_imem_w_en;
    logic [9:0]  o_imem_w_addr;
    logic [31:0] o_imem_w_data;
    logic        o_pipe_enable;
    logic        o_pipe_reset;
    logic        i_halt = 1'b0;
    logic [31:0] i_pc = '0;
    logic [4:0]  o_reg_r_addr;
    logic [31:0] i_reg_r_data;

    always #5 clk = ~clk;

    debug_unit dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (i_tx_done),
        .o_imem_w_en  (o_imem_w_en),
        .o_imem_w_addr(o_imem_w_addr),
        .o_imem_w_data(o_imem_w_data),
        .o_pipe_enable(o_pipe_enable),
        .o_pipe_reset (o_pipe_reset),
        .i_halt       (i_halt),
        .i_pc         (i_pc),
        .o_reg_r_addr (o_reg_r_addr),
        .i_reg_r_data (i_reg_r_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register file model with one cycle of read latency.
    logic [31:0] regs [32];
    always @(posedge clk) i_reg_r_data <= regs[o_reg_r_addr];

    // Event counters plus a UART tx model with random done latency.
    int         w_cnt = 0, pr_cnt = 0, en_cnt = 0, start_cnt = 0;
    int         stab_err = 0;
    int         max_delay = 4;
    int         wait_left = 0;
    logic       pending = 1'b0;
    logic [7:0] cap = '0;
    logic [7:0] tx_q [$];

    always @(negedge clk) begin
        i_tx_done = 1'b0;
        if (o_imem_w_en)   w_cnt++;
        if (o_pipe_reset)  pr_cnt++;
        if (o_pipe_enable) en_cnt++;
        if (o_tx_start) begin
            start_cnt++;
            tx_q.push_back(o_tx_data);
            if (pending) stab_err++;
            pending   = 1'b1;
            cap       = o_tx_data;
            wait_left = $urandom_range(max_delay, 1);
        end else if (pending) begin
            if (o_tx_data !== cap) stab_err++;
            if (wait_left <= 1) begin
                i_tx_done = 1'b1;
                pending   = 1'b0;
            end else begin
                wait_left--;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    logic [31:0] ld_q [$];

    // Load ld_q and check every write strobe the cycle after its 4th byte.
    task automatic run_load(input string tag);
        int w0, p0;
        w0 = w_cnt;
        p0 = pr_cnt;
        send_byte(CMD_LOAD);
        send_byte(8'(ld_q.size()));
        for (int i = 0; i < ld_q.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(ld_q[i] >> (24 - 8 * k)));
                if (k < 3) idle($urandom_range(2));
            end
            chk({tag, " wen"}, o_imem_w_en, 1'b1);
            chk({tag, " addr"}, o_imem_w_addr, 10'(i));
            chk({tag, " data"}, o_imem_w_data, ld_q[i]);
        end
        idle(4);
        chk({tag, " writes"}, w_cnt - w0, ld_q.size());
        chk({tag, " preset"}, pr_cnt - p0, 1);
    endtask

    int s0;
    task automatic arm_dump();
        tx_q.delete();
        s0 = start_cnt;
        i_pc = $urandom;
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
    endtask

    task automatic finish_dump(input string tag);
        int t;
        logic [31:0] ew;
        t = 0;
        while (tx_q.size() < 132 && t < 40000) begin
            @(posedge clk);
            t++;
        end
        chk({tag, " in time"}, t < 40000, 1'b1);
        idle(max_delay + 60);
        chk({tag, " bytes"}, tx_q.size(), 132);
        chk({tag, " starts"}, start_cnt - s0, 132);
        if (tx_q.size() == 132) begin
            for (int i = 0; i < 132; i++) begin
                ew = (i < 4) ? i_pc : regs[i / 4 - 1];
                chk($sformatf("%s byte%0d", tag, i), tx_q[i],
                    8'(ew >> (24 - 8 * (i % 4))));
            end
        end
        chk({tag, " stable"}, stab_err, 0);
    endtask

    int w0, p0, e0, t;

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = '0;
        idle(3);
        i_reset = 1'b0;
        idle(1);
        chk("rst ctl", {o_tx_start, o_imem_w_en, o_pipe_enable,
                        o_pipe_reset}, 4'b0);
        chk("rst tx", o_tx_data, 8'h0);
        chk("rst waddr", o_imem_w_addr, 10'h0);
        chk("rst wdata", o_imem_w_data, 32'h0);
        chk("rst raddr", o_reg_r_addr, 5'h0);

        ld_q = '{32'h12345678, 32'h9ABCDEF0};
        run_load("t1");
        ld_q.delete();
        repeat ($urandom_range(6, 1)) ld_q.push_back($urandom);
        run_load("t1r");

        w0 = w_cnt;
        p0 = pr_cnt;
        send_byte(CMD_LOAD);
        send_byte(8'h00);
        idle(4);
        chk("t2 writes", w_cnt - w0, 0);
        chk("t2 preset0", pr_cnt - p0, 0);
        send_byte(CMD_PRST);
        idle(4);
        chk("t2 preset1", pr_cnt - p0, 1);
        chk("t2 writes2", w_cnt - w0, 0);

        arm_dump();
        e0 = en_cnt;
        send_byte(CMD_STEP);
        finish_dump("t3");
        chk("t3 enables", en_cnt - e0, 1);

        arm_dump();
        e0 = en_cnt;
        send_byte(CMD_RUN);
        t = 0;
        while (en_cnt - e0 < 50 && t < 2000) begin
            idle(1);
            t++;
        end
        i_halt = 1'b1;
        finish_dump("t4");
        chk("t4 enables", en_cnt - e0, 50);

        arm_dump();
        e0 = en_cnt;
        send_byte(CMD_RUN);
        finish_dump("t4h");
        chk("t4h enables", en_cnt - e0, 0);
        i_halt = 1'b0;
        idle(2);

        w0 = w_cnt;
        send_byte(CMD_LOAD);
        send_byte(8'h02);
        for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k));
        send_byte(8'h11);
        send_byte(8'h22);
        idle(1);
        i_reset = 1'b1;
        idle(1);
        i_reset = 1'b0;
        idle(4);
        chk("t5 writes", w_cnt - w0, 1);
        chk("t5 idle", {o_imem_w_en, o_pipe_enable, o_tx_start}, 3'b0);
        ld_q = '{32'hCAFE0001};
        run_load("t5l");

        arm_dump();
        w0 = w_cnt;
        p0 = pr_cnt;
        e0 = en_cnt;
        send_byte(CMD_STEP);
        idle(3);
        send_byte(CMD_LOAD);
        send_byte(CMD_RUN);
        send_byte(CMD_PRST);
        send_byte(CMD_STEP);
        send_byte(8'($urandom));
        finish_dump("t5d");
        chk("t5d enables", en_cnt - e0, 1);
        chk("t5d writes", w_cnt - w0, 0);
        chk("t5d preset", pr_cnt - p0, 0);

        max_delay = 200;
        arm_dump();
        e0 = en_cnt;
        send_byte(CMD_STEP);
        finish_dump("t6");
        chk("t6 enables", en_cnt - e0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
